// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: 2-entry skid buffer between fetch and decode.
// The head entry drives the decoded field outputs; the skid entry absorbs one word of backpressure.
module if_id_stage #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc_plus4,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [IMM_W-1:0]  out_imm,
    output logic [25:0]       out_jaddr
);

    typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] head_instr_q, head_instr_d;
    logic [DATA_W-1:0] head_pc4_q, head_pc4_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [DATA_W-1:0] skid_pc4_q, skid_pc4_d;
    logic [DATA_W-1:0] in_pc4;
    logic              xfer_in;
    logic              xfer_out;

    assign in_pc4   = in_pc + DATA_W'(4);
    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            head_instr_q <= '0;
            head_pc4_q   <= '0;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            head_instr_q <= head_instr_d;
            head_pc4_q   <= head_pc4_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_pc4_d   = head_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    head_instr_d = in_instr;
                    head_pc4_d   = in_pc4;
                    state_d      = HALF;
                end
            end
            HALF: begin
                if (xfer_in && !xfer_out) begin
                    skid_instr_d = in_instr;
                    skid_pc4_d   = in_pc4;
                    state_d      = FULL;
                end else if (xfer_in && xfer_out) begin
                    head_instr_d = in_instr;
                    head_pc4_d   = in_pc4;
                end else if (xfer_out) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (xfer_out) begin
                    head_instr_d = skid_instr_q;
                    head_pc4_d   = skid_pc4_q;
                    state_d      = HALF;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A taken branch discards everything held plus the word offered alongside it.
        if (flush) begin
            state_d      = EMPTY;
            head_instr_d = head_instr_q;
            head_pc4_d   = head_pc4_q;
            skid_instr_d = skid_instr_q;
            skid_pc4_d   = skid_pc4_q;
        end
    end

    always_comb begin
        in_ready  = (state_q != FULL) && !rst;
        out_valid = (state_q == HALF) || (state_q == FULL);
    end

    assign out_instr    = head_instr_q;
    assign out_pc_plus4 = head_pc4_q;
    assign out_opcode   = head_instr_q[31:26];
    assign out_rs       = head_instr_q[25:21];
    assign out_rt       = head_instr_q[20:16];
    assign out_rd       = head_instr_q[15:11];
    assign out_shamt    = head_instr_q[10:6];
    assign out_funct    = head_instr_q[5:0];
    assign out_imm      = head_instr_q[IMM_W-1:0];
    assign out_jaddr    = head_instr_q[25:0];

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning the instruction and PC width.
REQ-002 The module SHALL have parameter IMM_W, default 16, meaning the immediate field width presented to the downstream sign-extension unit.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  fetch stage offers an instruction.
REQ-007 in_ready  output  1  stage accepts an instruction this cycle.
REQ-008 in_instr  input  DATA_W  fetched instruction word.
REQ-009 in_pc  input  DATA_W  address of the fetched instruction.
REQ-010 flush  input  1  discard all held and incoming instructions (branch/jump taken).
REQ-011 out_valid  output  1  decoded instruction available.
REQ-012 out_ready  input  1  downstream decode/execute consumes this cycle.
REQ-013 out_instr  output  DATA_W  held instruction word.
REQ-014 out_pc_plus4  output  DATA_W  held PC + 4.
REQ-015 out_opcode/out_rs/out_rt/out_rd/out_shamt/out_funct  output  6/5/5/5/5/6  instruction fields [31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0].
REQ-016 out_imm  output  IMM_W  instruction bits [IMM_W-1:0], unextended, for the sign-extension unit.
REQ-017 out_jaddr  output  26  instruction bits [25:0].

Function
REQ-018 The stage SHALL be a 2-entry skid buffer: a head register (drives outputs) and a skid register.
REQ-019 The state machine SHALL have states EMPTY (0 held), HALF (head only), FULL (head and skid).
REQ-020 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-021 in_ready SHALL be 1 in EMPTY and HALF, 0 in FULL, and 0 while rst is high; it SHALL depend on registered state only (no combinational path from out_ready).
REQ-022 out_valid SHALL be 1 exactly in HALF and FULL.
REQ-023 EMPTY: transfer in -> load head, go HALF.
REQ-024 HALF: in only -> load skid, go FULL; out only -> go EMPTY; in and out simultaneously -> load head with new entry, stay HALF.
REQ-025 FULL: transfer out -> move skid into head, go HALF; no out -> hold all.
REQ-026 An entry SHALL store {in_instr, in_pc + 4}; addition modulo 2^DATA_W (0xFFFFFFFC + 4 = 0x00000000).
REQ-027 All field outputs SHALL be combinational slices of the head instruction; latency in_valid acceptance -> out_valid SHALL be one cycle.
REQ-028 Order SHALL be preserved; no entry dropped or duplicated except by flush.
REQ-029 flush SHALL, at the next edge, force state EMPTY and ignore any same-cycle in transfer; a same-cycle out transfer still completes downstream; flush has priority over all transitions.
REQ-030 Data registers SHALL hold value when not loaded; output values while out_valid=0 carry no meaning beyond REQ-031.

Reset
REQ-031 rst high at a rising edge SHALL set state EMPTY, head and skid contents to 0, hence out_valid=0, out_instr=0, out_pc_plus4=0, all fields 0.
REQ-032 Reset SHALL take priority over flush and handshakes; asserting rst mid-operation in FULL discards both entries.
REQ-033 First accept possible in the first cycle after rst deasserts (in_ready=1).

Verification
REQ-034 Reset then single push: in_instr=0x2008FFFF, in_pc=0x00400000, out_ready=1 -> next cycle out_valid=1, out_opcode=0x08, out_rs=0, out_rt=8, out_imm=0xFFFF, out_pc_plus4=0x00400004; following cycle out_valid=0.
REQ-035 Backpressure: out_ready=0, push A then B -> state FULL, in_ready=0, out_instr=A; C held at input not accepted; raise out_ready -> outputs A, B, C in order, no loss.
REQ-036 Streaming: in_valid=1, out_ready=1 for 10 cycles with PCs 0x0..0x24 -> one output per cycle, in_ready constantly 1, out_pc_plus4 = PC+4 each.
REQ-037 Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming word discarded.
REQ-038 Wrap: in_pc=0xFFFFFFFC -> out_pc_plus4=0x00000000.
REQ-039 rst asserted in FULL for one cycle -> out_valid=0, out_instr=0, in_ready=0 during rst, 1 after.
